// File: rtl/tinyqv_ser_counter.sv
// Nibble-serial W-bit counter: one 4-bit nibble per cycle, host-driven nibble index.
// Optional serial >= compare against a W-bit register when TINYQV_SER_COUNTER_CMP_EN is defined.
module tinyqv_ser_counter #(
    parameter int unsigned NIBBLES = 8,
    parameter int unsigned STEP    = 1
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [$clog2(NIBBLES)-1:0] nibble_ct,
    input  logic                       inc,
    input  logic                       set,
    input  logic [3:0]                 data_in,
    output logic [3:0]                 data_out,
    output logic                       cy_out,
    output logic                       wrap
`ifdef TINYQV_SER_COUNTER_CMP_EN
    ,
    input  logic                       cmp_set,
    input  logic [3:0]                 cmp_data,
    output logic                       match
`endif
);

    localparam int unsigned       CW     = $clog2(NIBBLES);
    localparam logic [CW-1:0]     LAST   = CW'(NIBBLES - 1);
    localparam logic [3:0]        STEP_N = 4'(STEP);

    logic [3:0] r_mem [NIBBLES];
    logic       r_carry;
    logic       r_wrap;

    logic       w_valid;
    logic       w_first;
    logic       w_last;
    logic [3:0] w_old;
    logic [3:0] w_addend;
    logic       w_cin;
    logic [4:0] w_sum;
    logic       w_cy;
    logic [3:0] w_new;

    // Indices past the top nibble (non-power-of-two NIBBLES) read as zero and write nothing.
    always_comb begin
        w_valid  = 32'(nibble_ct) < NIBBLES;
        w_first  = nibble_ct == '0;
        w_last   = nibble_ct == LAST;
        w_old    = w_valid ? r_mem[nibble_ct] : '0;
        w_addend = (w_first && inc) ? STEP_N : '0;
        w_cin    = w_first ? 1'b0 : r_carry;
        w_sum    = {1'b0, w_old} + {1'b0, w_addend} + {4'b0000, w_cin};
        w_cy     = w_valid && !set && w_sum[4];
        w_new    = set ? data_in : w_sum[3:0];
    end

    assign data_out = w_old;
    assign cy_out   = w_cy;
    assign wrap     = r_wrap;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < NIBBLES; i++) begin
                r_mem[i] <= '0;
            end
            r_carry <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_wrap <= w_last && w_cy;
            if (w_valid) begin
                r_mem[nibble_ct] <= w_new;
                r_carry          <= w_cy;
            end
        end
    end

`ifdef TINYQV_SER_COUNTER_CMP_EN
    logic [3:0] r_cmp [NIBBLES];
    logic       r_ge;
    logic       r_match;

    logic [3:0] w_cmp_new;
    logic       w_ge_in;
    logic       w_ge;

    // Higher nibbles are visited later, so a strict difference there overrides the running result.
    always_comb begin
        w_cmp_new = cmp_set ? cmp_data : (w_valid ? r_cmp[nibble_ct] : '0);
        w_ge_in   = w_first ? 1'b1 : r_ge;
        if (w_new > w_cmp_new) begin
            w_ge = 1'b1;
        end else if (w_new < w_cmp_new) begin
            w_ge = 1'b0;
        end else begin
            w_ge = w_ge_in;
        end
    end

    assign match = r_match;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < NIBBLES; i++) begin
                r_cmp[i] <= '0;
            end
            r_ge    <= 1'b0;
            r_match <= 1'b0;
        end else if (w_valid) begin
            if (cmp_set) begin
                r_cmp[nibble_ct] <= cmp_data;
            end
            r_ge <= w_ge;
            if (w_last) begin
                r_match <= w_ge;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tinyqv_ser_counter.sv
// Directed self-checking bench for tinyqv_ser_counter: pass table on an 8-nibble instance,
// plus hand sequences for reset mid-pass, a 4-nibble STEP=3 instance and a 6-nibble instance.
module tb_tinyqv_ser_counter;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // 8-nibble, STEP=1 instance
    logic [2:0] ct8 = '0;
    logic       inc8 = 1'b0, set8 = 1'b0;
    logic [3:0] din8 = '0;
    logic [3:0] dout8;
    logic       cy8, wrap8;
    // 4-nibble, STEP=3 instance
    logic [1:0] ct4 = '0;
    logic       inc4 = 1'b0, set4 = 1'b0;
    logic [3:0] din4 = '0;
    logic [3:0] dout4;
    logic       cy4, wrap4;
    // 6-nibble instance (indices 6 and 7 are out of range)
    logic [2:0] ct6 = '0;
    logic       inc6 = 1'b0, set6 = 1'b0;
    logic [3:0] din6 = '0;
    logic [3:0] dout6;
    logic       cy6, wrap6;
`ifdef TINYQV_SER_COUNTER_CMP_EN
    logic       cs8 = 1'b0, cs4 = 1'b0, cs6 = 1'b0;
    logic [3:0] cd8 = '0, cd4 = '0, cd6 = '0;
    logic       m8, m4, m6;
`endif

    tinyqv_ser_counter #(.NIBBLES(8), .STEP(1)) u_dut8 (
        .clk(clk), .rstn(rstn), .nibble_ct(ct8), .inc(inc8), .set(set8), .data_in(din8),
        .data_out(dout8), .cy_out(cy8), .wrap(wrap8)
`ifdef TINYQV_SER_COUNTER_CMP_EN
        , .cmp_set(cs8), .cmp_data(cd8), .match(m8)
`endif
    );

    tinyqv_ser_counter #(.NIBBLES(4), .STEP(3)) u_dut4 (
        .clk(clk), .rstn(rstn), .nibble_ct(ct4), .inc(inc4), .set(set4), .data_in(din4),
        .data_out(dout4), .cy_out(cy4), .wrap(wrap4)
`ifdef TINYQV_SER_COUNTER_CMP_EN
        , .cmp_set(cs4), .cmp_data(cd4), .match(m4)
`endif
    );

    tinyqv_ser_counter #(.NIBBLES(6), .STEP(1)) u_dut6 (
        .clk(clk), .rstn(rstn), .nibble_ct(ct6), .inc(inc6), .set(set6), .data_in(din6),
        .data_out(dout6), .cy_out(cy6), .wrap(wrap6)
`ifdef TINYQV_SER_COUNTER_CMP_EN
        , .cmp_set(cs6), .cmp_data(cd6), .match(m6)
`endif
    );

    typedef struct {
        logic        inc0;      // inc at nibble 0
        logic        incx;      // inc at nibbles 1..7 (must be ignored)
        logic [7:0]  set_mask;  // nibbles written with set
        logic [31:0] set_val;   // data_in for each nibble
        logic [31:0] exp_pre;   // value read back during this pass
        logic        exp_cy7;   // cy_out at nibble 7
        logic        exp_wrap0; // wrap during nibble 0 of this pass
    } pass_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pass8(input pass_t p);
        logic [31:0] pre;
        pre = '0;
        for (int k = 0; k < 8; k++) begin
            ct8  = 3'(k);
            inc8 = (k == 0) ? p.inc0 : p.incx;
            set8 = p.set_mask[k];
            din8 = p.set_val[4*k +: 4];
            @(negedge clk);
            pre[4*k +: 4] = dout8;
            chk("wrap8", {31'b0, wrap8}, {31'b0, (k == 0) ? p.exp_wrap0 : 1'b0});
            if (k == 7) chk("cy8_n7", {31'b0, cy8}, {31'b0, p.exp_cy7});
            next_cycle();
        end
        inc8 = 1'b0;
        set8 = 1'b0;
        chk("value8", pre, p.exp_pre);
    endtask

    task automatic pass4(input logic inc0, input logic [3:0] mask, input logic [15:0] val,
                         output logic [15:0] pre, output logic cy3, output logic wrap0);
        pre = '0;
        cy3 = 1'b0;
        wrap0 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            ct4  = 2'(k);
            inc4 = (k == 0) ? inc0 : 1'b0;
            set4 = mask[k];
            din4 = val[4*k +: 4];
            @(negedge clk);
            pre[4*k +: 4] = dout4;
            if (k == 0) wrap0 = wrap4;
            if (k == 3) cy3 = cy4;
            next_cycle();
        end
        inc4 = 1'b0;
        set4 = 1'b0;
    endtask

`ifdef TINYQV_SER_COUNTER_CMP_EN
    task automatic cmp_pass(input logic inc0, input logic do_set, input logic [31:0] cnt,
                            input logic do_cmp, input logic [31:0] cmpv,
                            input logic check_m, input logic exp_m);
        for (int k = 0; k < 8; k++) begin
            ct8  = 3'(k);
            inc8 = (k == 0) ? inc0 : 1'b0;
            set8 = do_set;
            din8 = cnt[4*k +: 4];
            cs8  = do_cmp;
            cd8  = cmpv[4*k +: 4];
            @(negedge clk);
            if (check_m) chk("match8", {31'b0, m8}, {31'b0, exp_m});
            next_cycle();
        end
        inc8 = 1'b0;
        set8 = 1'b0;
        cs8  = 1'b0;
    endtask
`endif

    pass_t tbl [10];

    initial begin
        logic [15:0] pre4;
        logic        cy3, w0;

        tbl[0] = '{1'b1, 1'b0, 8'h00, 32'h0,        32'h0,        1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 8'h00, 32'h0,        32'h1,        1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 8'h00, 32'h0,        32'h2,        1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 8'hFF, 32'hFFFFFFFF, 32'h3,        1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 8'h00, 32'h0,        32'hFFFFFFFF, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 8'h01, 32'h0000000F, 32'h0,        1'b0, 1'b1};
        tbl[6] = '{1'b1, 1'b0, 8'h02, 32'h00000050, 32'hF,        1'b0, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 8'h00, 32'h0,        32'h50,       1'b0, 1'b0};
        tbl[8] = '{1'b1, 1'b1, 8'h00, 32'h0,        32'h50,       1'b0, 1'b0};
        tbl[9] = '{1'b0, 1'b0, 8'h00, 32'h0,        32'h51,       1'b0, 1'b0};

        rstn = 1'b0;
        repeat (3) next_cycle();
        rstn = 1'b1;
        chk("rst_wrap8", {31'b0, wrap8}, 32'h0);
        chk("rst_cy8", {31'b0, cy8}, 32'h0);
        chk("rst_dout4", {28'b0, dout4}, 32'h0);

        for (int i = 0; i < 10; i++) pass8(tbl[i]);

`ifdef TINYQV_SER_COUNTER_CMP_EN
        cmp_pass(1'b0, 1'b1, 32'h3, 1'b1, 32'h5, 1'b0, 1'b0);
        cmp_pass(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        cmp_pass(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        cmp_pass(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
        cmp_pass(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
        pass8('{1'b0, 1'b0, 8'hFF, 32'h00000051, 32'h6, 1'b0, 1'b0});
`endif

        // Load 0x0FFFFFFF, then reset during nibble 4 of an incrementing pass.
        pass8('{1'b0, 1'b0, 8'hFF, 32'h0FFFFFFF, 32'h51, 1'b0, 1'b0});
        for (int k = 0; k < 4; k++) begin
            ct8  = 3'(k);
            inc8 = (k == 0);
            next_cycle();
        end
        inc8 = 1'b0;
        ct8  = 3'd4;
        rstn = 1'b0;
        next_cycle();
        chk("midrst_dout8", {28'b0, dout8}, 32'h0);
        chk("midrst_cy8", {31'b0, cy8}, 32'h0);
        chk("midrst_wrap8", {31'b0, wrap8}, 32'h0);
        ct8 = 3'd0;
        next_cycle();
        rstn = 1'b1;
        pass8('{1'b0, 1'b0, 8'h00, 32'h0, 32'h0, 1'b0, 1'b0});

        // NIBBLES=4, STEP=3: 0xFFFE + 3 wraps to 0x0001.
        pass4(1'b0, 4'hF, 16'hFFFE, pre4, cy3, w0);
        chk("n4_load_pre", {16'b0, pre4}, 32'h0);
        pass4(1'b1, 4'h0, 16'h0, pre4, cy3, w0);
        chk("n4_pre_inc", {16'b0, pre4}, 32'hFFFE);
        chk("n4_cy3", {31'b0, cy3}, 32'h1);
        pass4(1'b0, 4'h0, 16'h0, pre4, cy3, w0);
        chk("n4_value", {16'b0, pre4}, 32'h0001);
        chk("n4_wrap", {31'b0, w0}, 32'h1);
        chk("n4_cy3_idle", {31'b0, cy3}, 32'h0);
        @(negedge clk);
        chk("n4_wrap_once", {31'b0, wrap4}, 32'h0);
        next_cycle();

        // NIBBLES=6: indices 6 and 7 read zero and ignore writes.
        for (int k = 0; k < 8; k++) begin
            ct6  = 3'(k);
            set6 = 1'b1;
            inc6 = 1'b1;
            din6 = (k < 6) ? 4'(k + 1) : 4'hA;
            @(negedge clk);
            if (k >= 6) begin
                chk("n6_oob_dout", {28'b0, dout6}, 32'h0);
                chk("n6_oob_cy", {31'b0, cy6}, 32'h0);
                chk("n6_oob_wrap", {31'b0, wrap6}, 32'h0);
            end
            next_cycle();
        end
        set6 = 1'b0;
        inc6 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            ct6 = 3'(k);
            @(negedge clk);
            chk("n6_read", {28'b0, dout6}, (k < 6) ? 32'(k + 1) : 32'h0);
            next_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tinyqv_ser_counter.md
TINYQV_SER_COUNTER -- requirements
Module: tinyqv_ser_counter

Interface
REQ-001 Parameter NIBBLES, default 8: counter width in 4-bit nibbles (legal 2..16; value width W = 4*NIBBLES).
REQ-002 Parameter STEP, default 1: increment amount added per incrementing pass (legal 1..15).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rstn  input  1  reset, synchronous, active-low.
REQ-005 nibble_ct  input  clog2(NIBBLES)  index of the nibble processed this cycle; 0 = least significant.
REQ-006 inc  input  1  request to add STEP; sampled only when nibble_ct == 0.
REQ-007 set  input  1  overwrite the current nibble with data_in.
REQ-008 data_in  input  4  write data for set.
REQ-009 data_out  output  4  current (pre-update) stored value of nibble nibble_ct.
REQ-010 cy_out  output  1  carry out of this cycle's nibble add; meaningful when nibble_ct == NIBBLES-1.
REQ-011 wrap  output  1  registered one-cycle pulse after a pass whose top-nibble add carried out.
REQ-012 Under CMP_EN only: cmp_set input 1, cmp_data input 4, match output 1.

Function
REQ-013 The host SHALL step nibble_ct 0,1,..,NIBBLES-1,0,.. one per cycle; a full sequence is a "pass".
REQ-014 The block SHALL hold W bits of count state as NIBBLES 4-bit entries addressed by nibble_ct.
REQ-015 data_out SHALL be combinational from the addressed stored nibble, before this cycle's update.
REQ-016 Addend at nibble 0 SHALL be (inc ? STEP : 0) with carry-in 0; at nibble k>0, addend 0 with carry-in = internal carry register.
REQ-017 On each edge with set low, the addressed nibble SHALL become (old + addend + carry-in) mod 16 and the carry register SHALL take the carry out.
REQ-018 On each edge with set high, the addressed nibble SHALL become data_in and the carry register SHALL be cleared; set wins over inc and carry.
REQ-019 inc at nibble_ct != 0 SHALL be ignored; an increment already in progress SHALL continue to propagate regardless of inc.
REQ-020 cy_out SHALL equal the carry out of the current nibble add (0 when set is high).
REQ-021 Wrap-around: all-ones plus STEP SHALL yield (STEP-1), with cy_out = 1 at nibble NIBBLES-1.
REQ-022 wrap SHALL be 1 for exactly the cycle after a nibble_ct == NIBBLES-1 cycle with cy_out = 1, else 0.
REQ-023 nibble_ct >= NIBBLES (non-power-of-two NIBBLES) SHALL cause no state change and data_out = 0.
REQ-024 Latency: a full W-bit increment SHALL complete in NIBBLES cycles; the new value is readable nibble-serially on the next pass.

Reset
REQ-025 While rstn is low at a rising edge: all count nibbles, carry register and wrap SHALL become 0 (plus compare nibbles and match under CMP_EN).
REQ-026 Reset mid-pass SHALL abandon the pass; the first pass after reset SHALL start from nibble 0 with count 0.

Configuration
REQ-027 Macro TINYQV_SER_COUNTER_CMP_EN, when defined, SHALL add a W-bit compare register and the cmp_set/cmp_data/match ports.
REQ-028 With it: cmp_set writes cmp_data into compare nibble nibble_ct at the edge; independent of set.
REQ-029 With it: a serial >= comparison SHALL run LSN-first on post-update count nibble vs post-update compare nibble; greater sets ge, less clears ge, equal keeps ge; ge starts at 1 at nibble 0.
REQ-030 With it: match SHALL register the final ge at the edge ending nibble NIBBLES-1 and hold it for the whole next pass.
REQ-031 Without it: no compare storage, ports absent, behaviour otherwise identical.

Verification
REQ-032 Reset, then 3 passes with inc=1 at nibble 0 (NIBBLES=8, STEP=1) -> readback pass shows value 0x00000003, wrap never 1.
REQ-033 set data_in=F every nibble for one pass, next pass inc=1 -> cy_out=1 at nibble 7, wrap=1 for one cycle, value 0x00000000.
REQ-034 Value 0x0000000F, inc=1 at nibble 0, set data_in=5 at nibble 1 -> value 0x00000050 (carry dropped).
REQ-035 NIBBLES=4, STEP=3, value 0xFFFE, one inc pass -> value 0x0001, cy_out=1 at nibble 3.
REQ-036 rstn low during nibble 4 of an incrementing pass on 0x0FFFFFFF -> all outputs 0, next readback 0x00000000.
REQ-037 CMP_EN: compare 0x00000005, count 4 then 5 then 6 over successive inc passes -> match 0, 1, 1 on passes following each.
